// File: rtl/controller_device_if.sv
// Controller port bundle between a host (latch/clock source and button
// source) and the controller_device emulation block.
interface controller_device_if;
    logic [7:0] buttons_in;
    logic       latch;
    logic       ctrl_clk;
    logic       data_B;
    logic [3:0] bits_sent;
    logic       read_done;

    // Host / button-source side
    modport master (
        output buttons_in,
        output latch,
        output ctrl_clk,
        input  data_B,
        input  bits_sent,
        input  read_done
    );

    // Emulated pad side
    modport slave (
        input  buttons_in,
        input  latch,
        input  ctrl_clk,
        output data_B,
        output bits_sent,
        output read_done
    );
endinterface

// File: rtl/controller_device.sv
// controller_device: answers a host latch/clock/data exchange like a
// physical 8-button pad. Snapshots buttons_in while latch is high and
// shifts it out MSB first on the active-low data_B line.
// Optional build macro: CONTROLLER_DEVICE_SYNC_EN adds two-flop
// synchronizers on latch and ctrl_clk (pin-to-action latency 3 cycles
// instead of 1).
module controller_device (
    input  logic              clk_in,
    input  logic              rst,
    controller_device_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic   latch_s;
    logic   clk_s;
    logic   latch_prev_q;
    logic   clk_prev_q;
    logic   latch_fall_s;
    logic   clk_rise_s;

    state_t     state_q,     state_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [3:0] bits_q,      bits_d;
    logic       read_done_q, read_done_d;
    logic       data_b_q;

`ifdef CONTROLLER_DEVICE_SYNC_EN
    logic latch_meta_q, latch_sync_q;
    logic clk_meta_q,   clk_sync_q;

    // Two-flop synchronizers for host pins arriving from an external console
    always_ff @(posedge clk_in) begin
        if (rst) begin
            latch_meta_q <= 1'b0;
            latch_sync_q <= 1'b0;
            clk_meta_q   <= 1'b0;
            clk_sync_q   <= 1'b0;
        end else begin
            latch_meta_q <= bus.latch;
            latch_sync_q <= latch_meta_q;
            clk_meta_q   <= bus.ctrl_clk;
            clk_sync_q   <= clk_meta_q;
        end
    end

    assign latch_s = latch_sync_q;
    assign clk_s   = clk_sync_q;
`else
    // Pins are already synchronous to clk_in and feed edge detection directly
    assign latch_s = bus.latch;
    assign clk_s   = bus.ctrl_clk;
`endif

    // Previous-value registers for edge detection
    always_ff @(posedge clk_in) begin
        if (rst) begin
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b0;
        end else begin
            latch_prev_q <= latch_s;
            clk_prev_q   <= clk_s;
        end
    end

    assign latch_fall_s = ~latch_s & latch_prev_q;
    assign clk_rise_s   = clk_s & ~clk_prev_q;

    // Next-state logic: latch dominates every state; otherwise shift on clock rises
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_d      = bits_q;
        read_done_d = 1'b0;
        if (latch_s) begin
            // Live snapshot every cycle the latch is high; also aborts a frame
            state_d = ST_LOAD;
            shreg_d = bus.buttons_in;
            bits_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    // A clock rise coinciding with the latch fall is not counted
                    if (latch_fall_s) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise_s) begin
                        shreg_d = {shreg_q[6:0], 1'b1};
                        if (bits_q == 4'd7) begin
                            bits_d      = 4'd8;
                            state_d     = ST_DONE;
                            read_done_d = 1'b1;
                        end else begin
                            bits_d = bits_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // Keep shifting fill ones so data_B reads "pressed" like a stock pad
                    if (clk_rise_s) begin
                        shreg_d = {shreg_q[6:0], 1'b1};
                    end else begin
                        shreg_d = shreg_q;
                    end
                    bits_d = 4'd8;
                end
                default: begin
                    state_d = ST_IDLE;
                    shreg_d = 8'h00;
                    bits_d  = 4'd0;
                end
            endcase
        end
    end

    // State and output registers; data_B is registered from the next shreg MSB
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= 8'h00;
            bits_q      <= 4'd0;
            read_done_q <= 1'b0;
            data_b_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_q      <= bits_d;
            read_done_q <= read_done_d;
            data_b_q    <= ~shreg_d[7];
        end
    end

    assign bus.data_B    = data_b_q;
    assign bus.bits_sent = bits_q;
    assign bus.read_done = read_done_q;

endmodule

// File: tb/tb_controller_device.sv
// Scoreboard testbench for controller_device. A frame-level model
// (snapshot byte + shift count) predicts data_B/bits_sent at each host
// sample point and every read_done pulse; a monitor compares.
module tb_controller_device;
`ifdef CONTROLLER_DEVICE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk_in;
    logic rst;
    controller_device_if bus ();

    controller_device dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] exp_q[$];   // {data_B, bits_sent}
    int         rd_q[$];    // one entry per expected read_done pulse
    logic       sample_req = 1'b0;

    // Reference model of the pad at frame level
    bit         m_idle = 1'b1;
    logic [7:0] m_snap = 8'h00;
    int         m_n    = 0;
    int         frame_id = 0;

    function automatic logic exp_data();
        logic [7:0] s;
        s = m_snap;
        if (m_idle)        return 1'b1;
        else if (m_n >= 8) return 1'b0;
        else               return ~s[3'(7 - m_n)];
    endfunction

    function automatic logic [3:0] exp_bits();
        if (m_idle)        return 4'd0;
        else if (m_n >= 8) return 4'd8;
        else               return 4'(m_n);
    endfunction

    // Monitor: compare sample points and every read_done pulse
    always @(negedge clk_in) begin
        if (sample_req) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sample_underflow: no expected entry");
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.data_B, bus.bits_sent} !== e) begin
                    n_err++;
                    $display("FAIL sample @%0t: data_B=%0b bits_sent=%0d, expected data_B=%0b bits_sent=%0d",
                             $time, bus.data_B, bus.bits_sent, e[4], e[3:0]);
                end
            end
        end
        if (bus.read_done !== 1'b0) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL read_done_unexpected @%0t: read_done=%b, expected 0", $time, bus.read_done);
            end else begin
                void'(rd_q.pop_front());
                if (bus.bits_sent !== 4'd8) begin
                    n_err++;
                    $display("FAIL read_done_bits @%0t: bits_sent=%0d, expected 8", $time, bus.bits_sent);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_phase();
        repeat ($urandom_range(4, 6)) step();
    endtask

    task automatic sample_point();
        exp_q.push_back({exp_data(), exp_bits()});
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
    endtask

    task automatic shift_clk();
        sample_point();
        if (!m_idle && m_n == 7) rd_q.push_back(frame_id);
        bus.ctrl_clk = 1'b1;
        wait_phase();
        if (!m_idle) m_n++;
        bus.ctrl_clk = 1'b0;
        wait_phase();
    endtask

    // Latch pulse; optionally toggles ctrl_clk while latch is high (ignored)
    task automatic do_latch(input logic [7:0] b, input bit clk_during);
        bus.buttons_in = b;
        bus.latch = 1'b1;
        wait_phase();
        m_idle = 1'b0; m_snap = b; m_n = 0; frame_id++;
        if (clk_during) begin
            bus.ctrl_clk = 1'b1; wait_phase();
            bus.ctrl_clk = 1'b0; wait_phase();
        end
        sample_point();
        bus.latch = 1'b0;
        wait_phase();
    endtask

    // Latch falls together with a ctrl_clk rise: that rise must not count
    task automatic latch_with_clk(input logic [7:0] b);
        bus.buttons_in = b;
        bus.latch = 1'b1;
        wait_phase();
        m_idle = 1'b0; m_snap = b; m_n = 0; frame_id++;
        bus.latch = 1'b0;
        bus.ctrl_clk = 1'b1;
        wait_phase();
        sample_point();
        bus.ctrl_clk = 1'b0;
        wait_phase();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        m_idle = 1'b1; m_n = 0;
        sample_point();
        rst = 1'b0;
        wait_phase();
    endtask

    task automatic frame(input logic [7:0] b, input int nsh, input bit wiggle);
        do_latch(b, 1'b0);
        for (int i = 0; i < nsh; i++) begin
            shift_clk();
            if (wiggle) bus.buttons_in = 8'($urandom);
        end
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus.buttons_in = 8'h00;
        bus.latch = 1'b0;
        bus.ctrl_clk = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state, then clock toggles with no latch are ignored
        sample_point();
        for (int i = 0; i < 4; i++) shift_clk();
        sample_point();

        // Pin-to-data_B latency on latch rise (first button pressed -> 0)
        bus.buttons_in = 8'h80;
        bus.latch = 1'b1;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.data_B === 1'b0) begin k = i; break; end
        end
        n_cmp++;
        if (k != LAT) begin
            n_err++;
            $display("FAIL latch_latency: measured %0d cycles, expected %0d", k, LAT);
        end
        wait_phase();
        m_idle = 1'b0; m_snap = 8'h80; m_n = 0; frame_id++;
        bus.latch = 1'b0;
        wait_phase();
        sample_point();

        // Pin-to-bits_sent latency on ctrl_clk rise
        bus.ctrl_clk = 1'b1;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.bits_sent === 4'd1) begin k = i; break; end
        end
        n_cmp++;
        if (k != LAT) begin
            n_err++;
            $display("FAIL clk_latency: measured %0d cycles, expected %0d", k, LAT);
        end
        wait_phase();
        m_n = 1;
        bus.ctrl_clk = 1'b0;
        wait_phase();
        sample_point();

        // 0xA5 full frame plus 3 extra clocks (saturation, fill ones)
        frame(8'hA5, 11, 1'b0);
        sample_point();

        // Abort after 3 shifts of 0xFF, then 0x01 full frame
        frame(8'hFF, 3, 1'b0);
        frame(8'h01, 8, 1'b0);
        sample_point();

        // Coincident latch fall / clock rise, then buttons change mid-frame
        latch_with_clk(8'h3C);
        for (int i = 0; i < 8; i++) begin
            shift_clk();
            bus.buttons_in = 8'($urandom);
        end
        sample_point();

        // Reset after 5 shifts discards the frame; clocks then ignored
        frame(8'h5A, 5, 1'b0);
        do_reset();
        shift_clk();
        shift_clk();

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            logic [7:0] b;
            int nsh;
            b   = 8'($urandom);
            nsh = $urandom_range(0, 11);
            case ($urandom_range(0, 3))
                0: begin
                    latch_with_clk(b);
                    for (int i = 0; i < nsh; i++) shift_clk();
                end
                1: begin
                    do_latch(b, 1'b1);
                    for (int i = 0; i < nsh; i++) shift_clk();
                end
                default: frame(b, nsh, 1'b1);
            endcase
            if ($urandom_range(0, 7) == 0) do_reset();
        end
        sample_point();
        repeat (4) step();

        n_cmp++;
        if (rd_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queues_drained: read_done pending=%0d samples pending=%0d, expected 0/0",
                     rd_q.size(), exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
